// File: rtl/arith_unit_seq.sv
// arith_unit_seq: add/sub in one cycle, shift-add multiply and
// restoring divide over WIDTH cycles, start/busy/valid handshake.
// Ports: clk, RST (async, active-low), A, B, ALU_FUN[1:0] opcode
// (00 ADD, 01 SUB, 10 MUL, 11 DIV), Arith_EN start; Arith_OUT,
// ALU_Carry, Div_Zero, Busy, Arith_Valid.
// Macro ARITH_DIV_EN builds the divider; without it DIV returns 0
// with Div_Zero=1 in one cycle.
module arith_unit_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [3:0]         ALU_FUN,
  input  logic               Arith_EN,
  output logic [2*WIDTH-1:0] Arith_OUT,
  output logic               ALU_Carry,
  output logic               Div_Zero,
  output logic               Busy,
  output logic               Arith_Valid
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] r_out;
  logic               r_carry;
  logic               r_dz;
  logic               r_valid;

  logic [1:0]         w_op;
  logic               w_acc;
  logic               w_iter;
  logic               w_last;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic [WIDTH:0]     w_msum;
  logic [WIDTH-1:0]   w_nhi;
  logic [WIDTH-1:0]   w_nlo;
  logic               w_unused;

  assign w_op     = ALU_FUN[1:0];
  assign w_unused = ^ALU_FUN[3:2];
  assign w_acc    = Arith_EN && (r_state == IDLE);
  assign w_last   = (r_state == RUN) && (r_cnt == CW'(WIDTH-1));
  assign w_add    = {1'b0, A} + {1'b0, B};
  assign w_sub    = {1'b0, A} - {1'b0, B};

  // Multiply: {r_hi, r_lo} holds partial product and the
  // remaining multiplier bits, shifted right each step.
  assign w_msum = {1'b0, r_hi}
                + {1'b0, (r_lo[0] ? r_a : '0)};

`ifdef ARITH_DIV_EN
  logic [WIDTH-1:0] r_b;
  logic             r_div;
  logic [WIDTH:0]   w_sh;
  logic [WIDTH:0]   w_dd;
  logic             w_ge;

  assign w_iter = (w_op == 2'b10)
               || ((w_op == 2'b11) && (|B));

  // Divide: r_hi is the partial remainder, r_lo shifts dividend
  // bits out at the top and quotient bits in at the bottom.
  assign w_sh = {r_hi, r_lo[WIDTH-1]};
  assign w_ge = (w_sh >= {1'b0, r_b});
  assign w_dd = w_sh - {1'b0, r_b};

  always_comb begin
    w_nhi = w_msum[WIDTH:1];
    w_nlo = {w_msum[0], r_lo[WIDTH-1:1]};
    if (r_div) begin
      w_nhi = w_ge ? w_dd[WIDTH-1:0] : w_sh[WIDTH-1:0];
      w_nlo = {r_lo[WIDTH-2:0], w_ge};
    end
  end
`else
  assign w_iter = (w_op == 2'b10);

  always_comb begin
    w_nhi = w_msum[WIDTH:1];
    w_nlo = {w_msum[0], r_lo[WIDTH-1:1]};
  end
`endif

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_acc && w_iter) w_next = RUN;
      RUN:     if (w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_out   <= '0;
      r_carry <= 1'b0;
      r_dz    <= 1'b0;
      r_valid <= 1'b0;
`ifdef ARITH_DIV_EN
      r_b     <= '0;
      r_div   <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      if (w_acc) begin
        r_cnt <= '0;
        r_a   <= A;
`ifdef ARITH_DIV_EN
        r_b   <= B;
        r_div <= w_op[0];
`endif
        unique case (w_op)
          2'b00: begin
            r_out   <= {{(WIDTH-1){1'b0}}, w_add};
            r_carry <= w_add[WIDTH];
            r_dz    <= 1'b0;
            r_valid <= 1'b1;
          end
          2'b01: begin
            r_out   <= {{WIDTH{1'b0}}, w_sub[WIDTH-1:0]};
            r_carry <= w_sub[WIDTH];
            r_dz    <= 1'b0;
            r_valid <= 1'b1;
          end
          2'b10: begin
            r_hi <= '0;
            r_lo <= B;
          end
          2'b11: begin
`ifdef ARITH_DIV_EN
            if (B == '0) begin
              r_out   <= {A, {WIDTH{1'b1}}};
              r_carry <= 1'b0;
              r_dz    <= 1'b1;
              r_valid <= 1'b1;
            end else begin
              r_hi <= '0;
              r_lo <= A;
            end
`else
            r_out   <= '0;
            r_carry <= 1'b0;
            r_dz    <= 1'b1;
            r_valid <= 1'b1;
`endif
          end
          default: ;
        endcase
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt + CW'(1);
        r_hi  <= w_nhi;
        r_lo  <= w_nlo;
        if (w_last) begin
          r_out   <= {w_nhi, w_nlo};
          r_carry <= 1'b0;
          r_dz    <= 1'b0;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign Arith_OUT   = r_out;
  assign ALU_Carry   = r_carry;
  assign Div_Zero    = r_dz;
  assign Arith_Valid = r_valid;
  assign Busy        = (r_state == RUN);

endmodule
